// File: rtl/hunter_sprite.sv
// Crosshair sprite: moves on frame ticks, erases/redraws five pixels
// on request, and reports a one-shot fire pulse with the aim point.
module hunter_sprite #(
   parameter int         X_INIT        = 80,
   parameter int         Y_INIT        = 60,
   parameter int         STEP          = 1,
   parameter logic [2:0] HUNTER_COLOUR = 3'b001
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       move_up,
   input  logic       move_down,
   input  logic       fire,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic       shot,
   output logic [7:0] shot_x,
   output logic [6:0] shot_y
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   localparam logic [8:0] STEP_X = 9'(STEP);
   localparam logic [7:0] STEP_Y = 8'(STEP);
   localparam logic [8:0] X_MAX  = 9'd158;
   localparam logic [7:0] Y_MAX  = 8'd118;

   state_t     state, state_nxt;
   logic [2:0] k, k_nxt;
   logic [7:0] cur_x, drw_x, x_nxt, base_x, pix_x;
   logic [6:0] cur_y, drw_y, y_nxt, base_y, pix_y;
   logic [8:0] x_wide;
   logic [7:0] y_wide;
   logic [2:0] pix_col;
   logic       pix_en;
   logic       fire_q;
   logic       fire_rise;

   // Saturating next position; opposing requests cancel on that axis
   always_comb begin
      x_wide = {1'b0, cur_x};
      y_wide = {1'b0, cur_y};
      if (move_left && !move_right) begin
         if (x_wide > STEP_X) x_wide = x_wide - STEP_X;
         else                 x_wide = 9'd1;
      end else if (move_right && !move_left) begin
         x_wide = x_wide + STEP_X;
      end
      if (move_up && !move_down) begin
         if (y_wide > STEP_Y) y_wide = y_wide - STEP_Y;
         else                 y_wide = 8'd1;
      end else if (move_down && !move_up) begin
         y_wide = y_wide + STEP_Y;
      end
      if (x_wide < 9'd1) x_wide = 9'd1;
      if (x_wide > X_MAX) x_wide = X_MAX;
      if (y_wide < 8'd1) y_wide = 8'd1;
      if (y_wide > Y_MAX) y_wide = Y_MAX;
      x_nxt = x_wide[7:0];
      y_nxt = y_wide[6:0];
   end

   // Current and last-drawn positions
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         cur_x <= 8'(X_INIT);
         cur_y <= 7'(Y_INIT);
         drw_x <= 8'(X_INIT);
         drw_y <= 7'(Y_INIT);
      end else begin
         if (state == IDLE && frame_tick) begin
            cur_x <= x_nxt;
            cur_y <= y_nxt;
         end
         if (state == DRAW && k == 3'd4) begin
            drw_x <= cur_x;
            drw_y <= cur_y;
         end
      end
   end

   // State and pixel-index register
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         k     <= 3'd0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   // Next-state: five pixels erased, five drawn, one done cycle
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ERASE;
               k_nxt     = 3'd0;
            end
         end
         ERASE: begin
            if (k == 3'd4) begin
               state_nxt = DRAW;
               k_nxt     = 3'd0;
            end else begin
               k_nxt = k + 3'd1;
            end
         end
         DRAW: begin
            if (k == 3'd4) begin
               state_nxt = DONE;
               k_nxt     = 3'd0;
            end else begin
               k_nxt = k + 3'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            k_nxt     = 3'd0;
         end
      endcase
   end

   // Pixel to emit this cycle: cross shape around the chosen centre
   always_comb begin
      pix_en  = (state == ERASE) || (state == DRAW);
      base_x  = (state == DRAW) ? cur_x : drw_x;
      base_y  = (state == DRAW) ? cur_y : drw_y;
      pix_col = (state == DRAW) ? HUNTER_COLOUR : 3'b000;
      pix_x   = base_x;
      pix_y   = base_y;
      unique case (k)
         3'd1:    pix_x = base_x - 8'd1;
         3'd2:    pix_x = base_x + 8'd1;
         3'd3:    pix_y = base_y - 7'd1;
         3'd4:    pix_y = base_y + 7'd1;
         default: begin
            pix_x = base_x;
            pix_y = base_y;
         end
      endcase
   end

   assign fire_rise = fire && !fire_q;

   // Registered outputs; coordinates hold while not plotting
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         x_out  <= 8'd0;
         y_out  <= 7'd0;
         colour <= 3'd0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         shot   <= 1'b0;
         shot_x <= 8'd0;
         shot_y <= 7'd0;
         fire_q <= 1'b0;
      end else begin
         plot   <= pix_en;
         busy   <= (state != IDLE);
         done   <= (state == DONE);
         fire_q <= fire;
         shot   <= fire_rise;
         if (pix_en) begin
            x_out  <= pix_x;
            y_out  <= pix_y;
            colour <= pix_col;
         end
         if (fire_rise) begin
            shot_x <= cur_x;
            shot_y <= cur_y;
         end
      end
   end

endmodule

// File: doc/hunter_sprite.md
HUNTER_SPRITE -- requirements
Module: hunter_sprite

Interface
REQ-001 The block SHALL have parameter X_INIT, default 80, meaning crosshair reset column.
REQ-002 The block SHALL have parameter Y_INIT, default 60, meaning crosshair reset row.
REQ-003 The block SHALL have parameter STEP, default 1, meaning pixels moved per accepted frame tick.
REQ-004 The block SHALL have parameter HUNTER_COLOUR, default 3'b001, meaning crosshair draw colour.
REQ-005 The block SHALL have port CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port frame_tick  in  1  one-cycle frame pulse.
REQ-008 The block SHALL have port start  in  1  one-cycle request to erase the old crosshair and draw the new one.
REQ-009 The block SHALL have ports move_left, move_right, move_up, move_down  in  1 each  level-sensitive direction requests.
REQ-010 The block SHALL have port fire  in  1  level trigger, synchronous to CLOCK_50.
REQ-011 The block SHALL have ports x_out  out  8 and y_out  out  7, the plot coordinate to the VGA adapter.
REQ-012 The block SHALL have ports colour  out  3 and plot  out  1, the plot colour and write strobe.
REQ-013 The block SHALL have ports busy  out  1 (sequence in progress) and done  out  1 (one-cycle completion pulse).
REQ-014 The block SHALL have ports shot  out  1 (one-cycle fire pulse), shot_x  out  8 and shot_y  out  7 (crosshair centre at fire).

Function
REQ-015 The block SHALL hold current position cur_x/cur_y and last-drawn position drw_x/drw_y.
REQ-016 The FSM SHALL have states IDLE, ERASE, DRAW and DONE, with a 3-bit pixel index k of 0..4.
REQ-017 In IDLE, frame_tick SHALL update the position in the next cycle: x -= STEP on left, x += STEP on right, y -= STEP on up, y += STEP on down.
REQ-018 Opposing requests asserted together (left+right, up+down) SHALL leave that axis unchanged.
REQ-019 Position SHALL saturate to x in [1,158] and y in [1,118], never wrapping; arithmetic SHALL be performed at 9/8 bits before clamping.
REQ-020 frame_tick outside IDLE SHALL be ignored; the movement is dropped, not queued.
REQ-021 start in IDLE SHALL enter ERASE with k=0 next cycle; start outside IDLE SHALL be ignored.
REQ-022 frame_tick and start asserted in the same IDLE cycle SHALL both be accepted, and DRAW SHALL use the updated position.
REQ-023 The pixel offsets SHALL be: k0 (0,0), k1 (-1,0), k2 (+1,0), k3 (0,-1), k4 (0,+1).
REQ-024 ERASE SHALL emit k0..k4 around drw_x/drw_y with colour 3'b000, one pixel per cycle, plot=1.
REQ-025 DRAW SHALL follow ERASE immediately and emit k0..k4 around cur_x/cur_y with HUNTER_COLOUR, plot=1.
REQ-026 On leaving DRAW, drw_x/drw_y SHALL be loaded with cur_x/cur_y.
REQ-027 DONE SHALL last one cycle with done=1 and plot=0, then return to IDLE.
REQ-028 All outputs SHALL be registered.
REQ-029 Timing: start sampled at cycle 0 SHALL give plot=1 on cycles 1-10 and done=1 on cycle 11.
REQ-030 busy SHALL be 1 in ERASE, DRAW and DONE.
REQ-031 plot SHALL be 0 in IDLE and DONE; x_out, y_out and colour SHALL hold their last values when plot=0.
REQ-032 A fire rising edge SHALL produce shot=1 for one cycle in any state, with shot_x/shot_y equal to cur_x/cur_y in the edge cycle; holding fire SHALL not produce a repeated pulse.

Reset
REQ-033 Assertion of reset SHALL immediately, without a clock edge, force: state IDLE, k=0, cur/drw = (X_INIT,Y_INIT), x_out=0, y_out=0, colour=0, plot=0, busy=0, done=0, shot=0, shot_x=0, shot_y=0, fire edge register=0.
REQ-034 Reset mid-sequence SHALL abandon the sequence, without completing the draw or asserting done.
REQ-035 Release of reset SHALL be synchronous; the first active edge after release SHALL evaluate from IDLE.

Verification
REQ-036 Reset, then start -> ten plots: (80,60),(79,60),(81,60),(80,59),(80,61) with colour 000, then the same five with 001; done=1 at cycle 11.
REQ-037 Hold move_right, four frame_ticks in IDLE, then start -> erase centre (80,60), draw centre (84,60).
REQ-038 Hold move_left from x=2, four frame_ticks -> x=1 and stays 1, no wrap to 255; likewise y clamps at 118 with move_down.
REQ-039 frame_tick with move_up on cycle 3 of a sequence -> position unchanged; left+right with tick in IDLE -> x unchanged.
REQ-040 fire held high for 20 cycles during DRAW at (84,60) -> exactly one shot pulse, shot_x=84, shot_y=60.
REQ-041 reset asserted at cycle 6 of a sequence -> plot=0 immediately, no done pulse; next start erases at (80,60).
